// File: rtl/mac_accumulator_pkg.sv
// Shared constants and state encoding for the MAC accumulation stage.
package mac_accumulator_pkg;

    localparam int ACC_WIDTH = 48;
    localparam int SUM_WIDTH = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product input and result output handshakes of the MAC accumulation stage.
interface mac_accumulator_if #(
    parameter int WIDTH = 48,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/mac_accumulator.sv
// Registers incoming products, feeds the external WIDTH-bit adder and keeps a
// saturating running sum, presenting the result after the product marked last.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    mac_accumulator_if.slave bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_sum
);

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             prod_v_q, prod_v_d;
    logic             last_q, last_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [WIDTH:0]   sat_res;

    // Returns {saturated, value}; a carry out or an earlier saturation pins the value at all ones.
    function automatic logic [WIDTH:0] sat_acc(input logic [WIDTH:0] sum, input logic sat_in);
        if (sum[WIDTH] || sat_in)
            return {1'b1, {WIDTH{1'b1}}};
        return {1'b0, sum[WIDTH-1:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return c;
        return c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign bus.in_ready  = (state_q != DONE) && !(prod_v_q && last_q);
    assign accept        = bus.in_valid && bus.in_ready;
    assign add_a         = acc_q;
    assign add_b         = prod_v_q ? prod_q : '0;
    assign sat_res       = sat_acc(add_sum, sat_q);

    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = acc_q;
    assign bus.out_sat   = sat_q;
    assign bus.out_count = cnt_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        last_d   = last_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
        prod_v_d = accept;

        if (accept) begin
            prod_d = bus.in_data;
            last_d = bus.in_last;
        end

        // Add stage: fold the held product into the accumulator.
        if (prod_v_q) begin
            acc_d   = sat_res[WIDTH-1:0];
            sat_d   = sat_res[WIDTH];
            cnt_d   = sat_inc(cnt_q);
            state_d = last_q ? DONE : ACCUM;
        end

        if (state_q == DONE && bus.out_ready) begin
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            last_q   <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            last_q   <= last_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator with the MAC adder modelled alongside it.
module tb_mac_accumulator;

    localparam int W = 48;
    localparam int C = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sat;
        logic [C-1:0] cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic [W-1:0] add_a, add_b;
    logic [W:0]   add_sum;

    int checks   = 0;
    int failures = 0;

    exp_t         sb[$];
    logic [W-1:0] m_acc = '0;
    logic         m_sat = 1'b0;
    logic [C-1:0] m_cnt = '0;

    mac_accumulator_if #(.WIDTH(W), .CNT_W(C)) bus ();

    mac_accumulator #(.WIDTH(W), .CNT_W(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .bus     (bus),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum)
    );

    // Existing combinational adder of the MAC top.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic model_clear();
        m_acc = '0;
        m_sat = 1'b0;
        m_cnt = '0;
    endtask

    task automatic model_term(input logic [W-1:0] d, input logic l);
        logic [W:0] s;
        s = {1'b0, m_acc} + {1'b0, d};
        if (m_sat || s[W]) begin
            m_acc = '1;
            m_sat = 1'b1;
        end else begin
            m_acc = s[W-1:0];
        end
        if (m_cnt != '1) m_cnt = m_cnt + 8'd1;
        if (l) begin
            sb.push_back('{data: m_acc, sat: m_sat, cnt: m_cnt});
            model_clear();
        end
    endtask

    // Leaves in_valid high so consecutive calls form a back-to-back stream.
    task automatic send(input logic [W-1:0] d, input logic l, output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!bus.in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
        end
        @(posedge clk); #1;
        model_term(d, l);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect(input string name);
        exp_t e;
        int   n;
        n = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!bus.out_valid || sb.size() == 0) begin
            failures++;
            $display("FAIL %s_valid out_valid=%0b required=1 queued=%0d", name, bus.out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (bus.out_data !== e.data) begin
                failures++;
                $display("FAIL %s_data got=%h required=%h", name, bus.out_data, e.data);
            end
            if (bus.out_sat !== e.sat) begin
                failures++;
                $display("FAIL %s_sat got=%0b required=%0b", name, bus.out_sat, e.sat);
            end
            if (bus.out_count !== e.cnt) begin
                failures++;
                $display("FAIL %s_count got=%0d required=%0d", name, bus.out_count, e.cnt);
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0 ||
            bus.out_sat !== 1'b0 || bus.out_count !== '0 || add_a !== '0 || add_b !== '0) begin
            failures++;
            $display("FAIL %s vld=%0b rdy=%0b data=%h sat=%0b cnt=%0d a=%h b=%h required vld=0 rdy=1 rest=0",
                     name, bus.out_valid, bus.in_ready, bus.out_data, bus.out_sat, bus.out_count, add_a, add_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset_state");
    endtask

    task automatic test_single();
        int w;
        send(48'h0000_0000_1234, 1'b1, w);
        idle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early out_valid=%0b required=0", bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_latency out_valid=%0b required=1", bus.out_valid);
        end
        collect("single");
    endtask

    task automatic test_back_to_back();
        int w;
        int total_waits;
        logic [W-1:0] vals[4] = '{48'd10, 48'd20, 48'd30, 48'd40};
        total_waits = 0;
        for (int i = 0; i < 4; i++) begin
            send(vals[i], i == 3, w);
            total_waits += w;
        end
        idle();
        checks++;
        if (total_waits != 0) begin
            failures++;
            $display("FAIL b2b_in_ready stall_cycles=%0d required=0", total_waits);
        end
        collect("b2b");
    endtask

    task automatic test_saturation();
        int w;
        send(48'hFFFF_FFFF_FFF0, 1'b0, w);
        send(48'h0000_0000_0020, 1'b0, w);
        send(48'd5, 1'b1, w);
        idle();
        collect("saturation");
    endtask

    task automatic test_backpressure();
        int w;
        int n;
        exp_t e;
        send(48'd3, 1'b0, w);
        send(48'd4, 1'b1, w);
        idle();
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        e = (sb.size() != 0) ? sb[0] : '0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d vld=%0b data=%h rdy=%0b required vld=1 data=%h rdy=0",
                         i, bus.out_valid, bus.out_data, bus.in_ready, e.data);
            end
            @(posedge clk); #1;
        end
        collect("bp_result");
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release rdy=%0b vld=%0b required rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
        send(48'd3, 1'b1, w);
        idle();
        collect("bp_next");
    endtask

    task automatic test_clear();
        int w;
        send(48'd100, 1'b0, w);
        send(48'd200, 1'b0, w);
        idle();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_clear();
        check_idle_outputs("clear_state");
        send(48'd9, 1'b1, w);
        idle();
        collect("clear_next");
    endtask

    task automatic test_reset_mid();
        int w;
        int n;
        send(48'd5, 1'b1, w);
        idle();
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pending out_valid=%0b required=1", bus.out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        model_clear();
        check_idle_outputs("rst_mid_state");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_clear();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream accumulation stage of the MAC datapath.
- Accepts a stream of 48-bit unsigned products over a valid/ready handshake and registers each one.
- Drives both operands of the existing 48-bit combinational adder (49-bit sum) and registers the sum back as the running accumulator, with saturation.
- Presents the final accumulated value with an output valid/ready handshake after the product marked last.

Parameters:
- WIDTH, 48, operand/accumulator width; must match adder operand width; sum is WIDTH+1 bits.
- CNT_W, 8, width of the accumulated-term counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear: abandons the current accumulation.
- in_valid  input  1  product valid.
- in_ready  output  1  block can accept a product this cycle.
- in_data  input  WIDTH  unsigned product.
- in_last  input  1  product is the final term of this accumulation.
- add_a  output  WIDTH  adder operand A = accumulator register.
- add_b  output  WIDTH  adder operand B = registered product, or 0 when none is held.
- add_sum  input  WIDTH+1  combinational adder result for add_a+add_b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  accumulated (possibly saturated) value.
- out_sat  output  1  saturation occurred in this accumulation.
- out_count  output  CNT_W  number of terms accumulated, saturating at all ones.

Behaviour:
- Reset (rst=1 at edge):
  - acc_q=0, prod_q=0, prod_v=0, last_q=0, sat_q=0, cnt_q=0, state=IDLE.
  - out_valid=0; in_ready=1 from the first cycle after reset.
- Priority: rst > clr > normal operation.
- clr has the same effect as rst on all state, including dropping any held product and any pending result.
- States:
  - IDLE: no terms accumulated yet.
  - ACCUM: at least one term accumulated.
  - DONE: result held.
- in_ready = (state != DONE) && !(prod_v && last_q).
  - Once a last product is captured, no further product is accepted until the result is consumed.
- Capture stage:
  - On in_valid && in_ready: prod_q <= in_data, last_q <= in_last, prod_v <= 1.
  - Otherwise prod_v <= 0.
- Add stage, when prod_v=1, in the same cycle capture may occur:
  - If add_sum[WIDTH]=1 or sat_q=1: acc_q <= all ones, sat_q <= 1. Otherwise acc_q <= add_sum[WIDTH-1:0].
  - Once saturated, acc_q holds all ones for the rest of the accumulation.
  - cnt_q <= cnt_q+1, saturating at 2^CNT_W-1.
  - state <= DONE if last_q, else ACCUM.
- Throughput and latency:
  - One product per cycle.
  - Latency from accepting the last product to out_valid=1 is 2 cycles: capture, then add.
- DONE:
  - out_valid=1; out_data=acc_q, out_sat=sat_q, out_count=cnt_q, all stable while out_ready=0.
  - On out_ready=1: acc_q, sat_q and cnt_q go to 0, state <= IDLE, and in_ready=1 in the next cycle.
- A last product accepted in IDLE gives a one-term accumulation: result = that product, count 1.
- Zero-valued products are counted normally.
- clr asserted while out_valid=1: the result is dropped, out_valid=0 in the next cycle.
- Outputs other than in_ready, add_a and add_b are driven directly from registers.
- add_a and add_b are combinational from registers only; there is no path from in_* to add_*.

Decomposition:
- Shared package holds:
  - ACC_WIDTH=48 and SUM_WIDTH=49 constants.
  - An enum for states IDLE/ACCUM/DONE.
- No sub-module. The adder stays instantiated at the MAC top and connects through add_a/add_b/add_sum.
- The bench instantiates the existing adder alongside this block.

Test Plan:
- Single term: push 48'h0000_0000_1234 with last=1 -> out_valid exactly 2 cycles after accept; out_data=48'h1234, out_count=1, out_sat=0.
- Back-to-back stream: push 10, 20, 30, 40 (last on 40) with in_valid held high -> in_ready stays 1 for all four; out_data=100, out_count=4.
- Saturation: push 48'hFFFF_FFFF_FFF0 then 48'h20, then 5 with last=1 -> out_data=48'hFFFF_FFFF_FFFF, out_sat=1, out_count=3.
- Output backpressure: complete a sum of 7 and hold out_ready=0 for 5 cycles -> out_valid and out_data=7 stable and in_ready=0; on out_ready=1, in_ready=1 next cycle; next accumulation of 3 (last) -> out_data=3.
- Clear mid-operation: push 100, 200, assert clr in the cycle after the 200 is accepted, then push 9 with last=1 -> out_data=9, out_count=1.
- Reset mid-operation: rst with out_valid=1 -> out_valid=0, in_ready=1 on the following cycle, all outputs zero.
